fp_alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `fp_alu` floating-point core (IEEE 754 single, `ce`/`sclr`/`rdy` interface) among several requesters, such as the CORDIC angle update and the x/y fixed-to-float accumulators. The block accepts one request per operation and sequences the ALU through clear, enable and wait phases. It returns the result tagged with the requester ID and converts a missing `rdy` into a timeout error. It sits between the requesting datapaths and the single ALU instance.

---
 rtl/fp_alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_fp_alu_arbiter.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one fp_alu among NREQ requesters.
// Sequences clear/enable/wait phases, tags results and flags timeouts.
module fp_alu_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [32*NREQ-1:0]   req_a_i,
    input  logic [32*NREQ-1:0]   req_b_i,
    input  logic [6*NREQ-1:0]    req_op_i,
    output logic                 resp_valid_o,
    output logic [IDW-1:0]       resp_id_o,
    output logic [31:0]          resp_result_o,
    output logic                 resp_err_o,
    output logic                 busy_o,
    output logic [7:0]           err_count_o,
    output logic [31:0]          alu_a_o,
    output logic [31:0]          alu_b_o,
    output logic [5:0]           alu_op_o,
    output logic                 alu_ce_o,
    output logic                 alu_sclr_o,
    input  logic [31:0]          alu_result_i,
    input  logic                 alu_rdy_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_RESP
    } state_e;

    state_e         state_q;
    logic [IDW-1:0] last_q;
    logic [IDW-1:0] cur_q;
    logic [IDW-1:0] resp_id_q;
    logic [31:0]    a_q;
    logic [31:0]    b_q;
    logic [5:0]     op_q;
    logic [31:0]    res_q;
    logic           err_q;
    logic [7:0]     cnt_q;
    logic [7:0]     cnt_d;
    logic [7:0]     errc_q;
    logic [7:0]     errc_d;

    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand;
    logic           gnt_found;
    logic           timeout;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(last_q) + i) % NREQ);
            if (!gnt_found && req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (!rst_i && state_q == S_IDLE && gnt_found) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign cnt_d   = cnt_q + 8'd1;
    assign errc_d  = (errc_q == 8'hFF) ? errc_q : errc_q + 8'd1;
    assign timeout = (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            last_q    <= IDW'(NREQ - 1);
            cur_q     <= '0;
            resp_id_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            errc_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (gnt_found) begin
                        a_q     <= req_a_i[32*gnt_idx +: 32];
                        b_q     <= req_b_i[32*gnt_idx +: 32];
                        op_q    <= req_op_i[6*gnt_idx +: 6];
                        cur_q   <= gnt_idx;
                        last_q  <= gnt_idx;
                        state_q <= S_CLR;
                    end
                end
                S_CLR: begin
                    cnt_q   <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    cnt_q <= cnt_d;
                    // A late rdy on the final cycle still beats the timeout.
                    if (alu_rdy_i) begin
                        res_q     <= alu_result_i;
                        err_q     <= 1'b0;
                        resp_id_q <= cur_q;
                        state_q   <= S_RESP;
                    end else if (timeout) begin
                        res_q     <= '0;
                        err_q     <= 1'b1;
                        resp_id_q <= cur_q;
                        errc_q    <= errc_d;
                        state_q   <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign alu_ce_o      = (state_q == S_RUN);
    assign alu_sclr_o    = rst_i | (state_q == S_CLR);
    assign resp_valid_o  = (state_q == S_RESP);
    assign resp_id_o     = resp_id_q;
    assign resp_result_o = res_q;
    assign resp_err_o    = err_q;
    assign err_count_o   = errc_q;
    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign alu_op_o      = op_q;

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Bench for fp_alu_arbiter: scenario tasks plus randomized traffic
// checked against a grant/latency/result model and a behavioural ALU.
module tb_fp_alu_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [23:0]  req_op;
    logic         resp_valid;
    logic [1:0]   resp_id;
    logic [31:0]  resp_result;
    logic         resp_err;
    logic         busy;
    logic [7:0]   err_count;
    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    logic [5:0]   alu_op;
    logic         alu_ce;
    logic         alu_sclr;
    logic [31:0]  alu_result;
    logic         alu_rdy;

    int errors = 0;
    int checks = 0;

    fp_alu_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
        .resp_valid_o(resp_valid), .resp_id_o(resp_id),
        .resp_result_o(resp_result), .resp_err_o(resp_err),
        .busy_o(busy), .err_count_o(err_count),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_ce_o(alu_ce), .alu_sclr_o(alu_sclr),
        .alu_result_i(alu_result), .alu_rdy_i(alu_rdy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: rdy on RUN cycle rdy_at (0 = never), random rdy noise
    // whenever ce is low, which the arbiter must ignore.
    int   rdy_at = 0;
    int   run_cnt = 0;
    logic noise = 1'b0;

    function automatic logic [31:0] fp_model(logic [31:0] a, logic [31:0] b,
                                             logic [5:0] op);
        if (a == 32'h3F800000 && b == 32'h40000000 && op == 6'd0)
            return 32'h40400000;
        if (a == 32'h40A00000 && b == 32'h3F800000 && op == 6'd1)
            return 32'h40800000;
        return a ^ {b[15:0], b[31:16]} ^ {26'd0, op} ^ 32'h5A5A0000;
    endfunction

    always @(posedge clk) begin
        noise <= 1'($urandom_range(0, 1));
        if (alu_sclr) run_cnt <= 0;
        else if (alu_ce) run_cnt <= run_cnt + 1;
    end

    always_comb begin
        alu_result = fp_model(alu_a, alu_b, alu_op);
        if (alu_ce) alu_rdy = (rdy_at > 0) && (run_cnt == rdy_at - 1);
        else alu_rdy = noise;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int id, input logic [31:0] a,
                           input logic [31:0] b, input logic [5:0] op);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_op[id*6 +: 6]  = op;
    endtask

    task automatic wait_grant(output int gid, output bit onehot);
        gid = -1;
        onehot = 1'b0;
        #1;
        for (int n = 0; n < 60; n++) begin
            if (req_ready != 4'd0) begin
                onehot = $onehot(req_ready);
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i]) gid = i;
                return;
            end
            tick();
        end
    endtask

    // Called in the accept cycle T; returns latency of resp_valid from T.
    task automatic wait_resp(input int drop, input int scr,
                             output int lat, output int sclr_at,
                             output int sclr_n, output bit a_stable,
                             output logic [31:0] a_cap,
                             output logic [31:0] res, output logic err,
                             output logic [1:0] rid);
        lat = -1;
        sclr_at = -1;
        sclr_n = 0;
        a_stable = 1'b1;
        a_cap = '0;
        res = '0;
        err = 1'b0;
        rid = '0;
        for (int c = 1; c <= TMO + 10; c++) begin
            tick();
            if (c == 1) begin
                a_cap = alu_a;
                if (drop >= 0) req_valid[drop] = 1'b0;
                if (scr >= 0) req_a[scr*32 +: 32] = 32'hFFFFFFFF;
            end
            if (alu_sclr) begin
                sclr_n++;
                if (sclr_at < 0) sclr_at = c;
            end
            if (alu_ce && alu_a !== a_cap) a_stable = 1'b0;
            if (resp_valid) begin
                lat = c;
                res = resp_result;
                err = resp_err;
                rid = resp_id;
                return;
            end
        end
    endtask

    int          gid, lat, sclr_at, sclr_n;
    bit          onehot, a_stable;
    logic [31:0] a_cap, res;
    logic        err;
    logic [1:0]  rid;

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        tick();
        tick();
        #1;
        checks++;
        if (alu_sclr !== 1'b1) begin
            errors++; $display("FAIL rst_sclr got=%b exp=1", alu_sclr);
        end
        checks++;
        if (req_ready !== 4'd0) begin
            errors++; $display("FAIL rst_ready got=%h exp=0", req_ready);
        end
        checks++;
        if ({resp_valid, busy, alu_ce, resp_err} !== 4'd0) begin
            errors++;
            $display("FAIL rst_flags got=%b exp=0000",
                     {resp_valid, busy, alu_ce, resp_err});
        end
        checks++;
        if ({err_count, resp_id, resp_result} !== 42'd0) begin
            errors++;
            $display("FAIL rst_resp cnt=%h id=%h res=%h exp=0",
                     err_count, resp_id, resp_result);
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== 70'd0) begin
            errors++;
            $display("FAIL rst_alu a=%h b=%h op=%h exp=0", alu_a, alu_b, alu_op);
        end
        req_valid = '0;
        rst = 1'b0;
        tick();
        checks++;
        if (alu_sclr !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_rst sclr=%b busy=%b exp=0 0", alu_sclr, busy);
        end
    endtask

    task automatic test_single_add();
        apply_reset();
        rdy_at = 5;
        set_req(0, 32'h3F800000, 32'h40000000, 6'd0);
        req_valid[0] = 1'b1;
        wait_grant(gid, onehot);
        checks++;
        if (gid !== 0) begin
            errors++; $display("FAIL add_grant got=%0d exp=0", gid);
        end
        wait_resp(0, -1, lat, sclr_at, sclr_n, a_stable, a_cap, res, err, rid);
        checks++;
        if (lat !== 7) begin
            errors++; $display("FAIL add_latency got=%0d exp=7", lat);
        end
        checks++;
        if (sclr_at !== 1 || sclr_n !== 1) begin
            errors++;
            $display("FAIL add_sclr at=%0d n=%0d exp=1 1", sclr_at, sclr_n);
        end
        checks++;
        if (res !== 32'h40400000 || err !== 1'b0 || rid !== 2'd0) begin
            errors++;
            $display("FAIL add_resp res=%h err=%b id=%0d exp=40400000 0 0",
                     res, err, rid);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        rdy_at = 2;
        for (int i = 0; i < NREQ; i++)
            set_req(i, $urandom, $urandom, 6'($urandom));
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            wait_grant(gid, onehot);
            checks++;
            if (gid !== k % NREQ || !onehot) begin
                errors++;
                $display("FAIL rr_grant%0d got=%0d onehot=%b exp=%0d",
                         k, gid, onehot, k % NREQ);
            end
            wait_resp(-1, -1, lat, sclr_at, sclr_n, a_stable, a_cap,
                      res, err, rid);
            checks++;
            if (rid !== 2'(k % NREQ) || lat !== 4) begin
                errors++;
                $display("FAIL rr_resp%0d id=%0d lat=%0d exp=%0d 4",
                         k, rid, lat, k % NREQ);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        logic [31:0] a3, b3;
        apply_reset();
        rdy_at = 0;
        set_req(2, 32'h11112222, 32'h33334444, 6'd1);
        req_valid[2] = 1'b1;
        wait_grant(gid, onehot);
        wait_resp(2, -1, lat, sclr_at, sclr_n, a_stable, a_cap, res, err, rid);
        checks++;
        if (lat !== TMO + 2) begin
            errors++; $display("FAIL tmo_latency got=%0d exp=%0d", lat, TMO + 2);
        end
        checks++;
        if (err !== 1'b1 || res !== 32'd0 || rid !== 2'd2) begin
            errors++;
            $display("FAIL tmo_resp err=%b res=%h id=%0d exp=1 0 2",
                     err, res, rid);
        end
        checks++;
        if (err_count !== 8'd1) begin
            errors++; $display("FAIL tmo_count got=%0d exp=1", err_count);
        end
        rdy_at = 3;
        a3 = $urandom;
        b3 = $urandom;
        set_req(3, a3, b3, 6'd0);
        req_valid[3] = 1'b1;
        wait_grant(gid, onehot);
        wait_resp(3, -1, lat, sclr_at, sclr_n, a_stable, a_cap, res, err, rid);
        checks++;
        if (err !== 1'b0 || lat !== 5 || res !== fp_model(a3, b3, 6'd0)
            || err_count !== 8'd1) begin
            errors++;
            $display("FAIL tmo_recover err=%b lat=%0d res=%h cnt=%0d exp=0 5 %h 1",
                     err, lat, res, err_count, fp_model(a3, b3, 6'd0));
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen_resp;
        bit sclr_ok;
        apply_reset();
        rdy_at = 10;
        set_req(1, $urandom, $urandom, 6'd0);
        req_valid[1] = 1'b1;
        wait_grant(gid, onehot);
        tick();
        req_valid[1] = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        seen_resp = 1'b0;
        sclr_ok = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (!alu_sclr) sclr_ok = 1'b0;
            if (resp_valid) seen_resp = 1'b1;
        end
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (resp_valid) seen_resp = 1'b1;
        end
        checks++;
        if (!sclr_ok) begin
            errors++; $display("FAIL midrst_sclr got=0 exp=1");
        end
        checks++;
        if (seen_resp) begin
            errors++; $display("FAIL midrst_noresp got=1 exp=0");
        end
        rdy_at = 2;
        set_req(0, $urandom, $urandom, 6'd0);
        set_req(2, $urandom, $urandom, 6'd0);
        req_valid = 4'b0101;
        wait_grant(gid, onehot);
        checks++;
        if (gid !== 0) begin
            errors++; $display("FAIL midrst_grant got=%0d exp=0", gid);
        end
        wait_resp(0, -1, lat, sclr_at, sclr_n, a_stable, a_cap, res, err, rid);
        wait_grant(gid, onehot);
        checks++;
        if (gid !== 2) begin
            errors++; $display("FAIL midrst_next got=%0d exp=2", gid);
        end
        wait_resp(2, -1, lat, sclr_at, sclr_n, a_stable, a_cap, res, err, rid);
    endtask

    task automatic test_operand_latch();
        rdy_at = 4;
        set_req(1, 32'h40A00000, 32'h3F800000, 6'd1);
        req_valid[1] = 1'b1;
        wait_grant(gid, onehot);
        wait_resp(1, 1, lat, sclr_at, sclr_n, a_stable, a_cap, res, err, rid);
        checks++;
        if (a_cap !== 32'h40A00000 || !a_stable) begin
            errors++;
            $display("FAIL latch_a got=%h stable=%b exp=40a00000 1",
                     a_cap, a_stable);
        end
        checks++;
        if (res !== 32'h40800000 || rid !== 2'd1) begin
            errors++;
            $display("FAIL latch_res got=%h id=%0d exp=40800000 1", res, rid);
        end
    endtask

    task automatic test_rdy_at_timeout();
        logic [7:0]  cnt0;
        logic [31:0] a0, b0;
        cnt0 = err_count;
        rdy_at = TMO;
        a0 = $urandom;
        b0 = $urandom;
        set_req(0, a0, b0, 6'd5);
        req_valid[0] = 1'b1;
        wait_grant(gid, onehot);
        wait_resp(0, -1, lat, sclr_at, sclr_n, a_stable, a_cap, res, err, rid);
        checks++;
        if (err !== 1'b0 || lat !== TMO + 2 || res !== fp_model(a0, b0, 6'd5)) begin
            errors++;
            $display("FAIL race_resp err=%b lat=%0d res=%h exp=0 %0d %h",
                     err, lat, res, TMO + 2, fp_model(a0, b0, 6'd5));
        end
        checks++;
        if (err_count !== cnt0) begin
            errors++; $display("FAIL race_count got=%0d exp=%0d", err_count, cnt0);
        end
    endtask

    task automatic test_random();
        int          last;
        logic [3:0]  pend;
        logic [31:0] ma [4];
        logic [31:0] mb [4];
        logic [5:0]  mo [4];
        int          ecnt;
        int          eg;
        bit          tmo;
        int          elat;
        logic [31:0] eres;
        apply_reset();
        last = NREQ - 1;
        pend = '0;
        ecnt = 0;
        for (int it = 0; it < 40; it++) begin
            logic [3:0] nb;
            nb = 4'($urandom_range(0, 15));
            if ((pend | nb) == 4'd0) nb[$urandom_range(0, 3)] = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (nb[i] && !pend[i]) begin
                    ma[i] = $urandom;
                    mb[i] = $urandom;
                    mo[i] = 6'($urandom);
                    set_req(i, ma[i], mb[i], mo[i]);
                    pend[i] = 1'b1;
                end
            end
            req_valid = pend;
            rdy_at = $urandom_range(0, TMO + 6);
            eg = -1;
            for (int i = 1; i <= NREQ; i++)
                if (eg < 0 && pend[(last + i) % NREQ]) eg = (last + i) % NREQ;
            wait_grant(gid, onehot);
            checks++;
            if (gid !== eg || !onehot) begin
                errors++;
                $display("FAIL rnd_grant%0d got=%0d exp=%0d", it, gid, eg);
            end
            if (gid < 0) continue;
            wait_resp(gid, -1, lat, sclr_at, sclr_n, a_stable, a_cap,
                      res, err, rid);
            tmo = (rdy_at == 0) || (rdy_at > TMO);
            elat = tmo ? TMO + 2 : rdy_at + 2;
            eres = tmo ? 32'd0 : fp_model(ma[eg], mb[eg], mo[eg]);
            if (tmo && ecnt < 255) ecnt++;
            pend[gid] = 1'b0;
            last = eg;
            checks++;
            if (lat !== elat || res !== eres || err !== tmo
                || rid !== 2'(eg) || a_cap !== ma[eg]) begin
                errors++;
                $display("FAIL rnd_resp%0d lat=%0d res=%h err=%b id=%0d a=%h exp=%0d %h %b %0d %h",
                         it, lat, res, err, rid, a_cap,
                         elat, eres, tmo, eg, ma[eg]);
            end
            checks++;
            if (err_count !== 8'(ecnt)) begin
                errors++;
                $display("FAIL rnd_count%0d got=%0d exp=%0d", it, err_count, ecnt);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        test_reset();
        test_single_add();
        test_round_robin();
        test_timeout();
        test_reset_mid_run();
        test_operand_latch();
        test_rdy_at_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
